// File: rtl/lutram_pkg.sv
// Shared geometry constants for the 64-deep LUT-RAM FIFO.
package lutram_pkg;

    localparam int LUTRAM_DEPTH = 64;
    localparam int LUTRAM_AW    = 6;
    localparam int LUTRAM_LW    = 7;

endpackage

// File: rtl/lutram_sdp64.sv
// 64-deep distributed RAM: synchronous write port, asynchronous read port.
module lutram_sdp64
    import lutram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 WCLK,
    input  logic                 WE,
    input  logic [LUTRAM_AW-1:0] A,
    input  logic [DATA_W-1:0]    D,
    input  logic [LUTRAM_AW-1:0] DPRA,
    output logic [DATA_W-1:0]    DPO
);

    // One 64x1 dual-port slice per data bit.
    for (genvar g = 0; g < DATA_W; g++) begin : g_slice
        logic [LUTRAM_DEPTH-1:0] bits;

        always_ff @(posedge WCLK) begin
            if (WE) begin
                bits[A] <= D[g];
            end
        end

        assign DPO[g] = bits[DPRA];
    end

endmodule

// File: rtl/lutram_fifo64.sv
// 64-entry LUT-RAM FIFO with a registered first-word-fall-through output.
module lutram_fifo64
    import lutram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WR_EN,
    input  logic [DATA_W-1:0]    WR_DATA,
    output logic                 FULL,
    output logic                 RD_VALID,
    input  logic                 RD_READY,
    output logic [DATA_W-1:0]    RD_DATA,
    output logic [LUTRAM_LW-1:0] LEVEL,
    output logic                 ERR_OVF
);

    localparam logic [LUTRAM_LW-1:0] CNT_FULL = LUTRAM_LW'(LUTRAM_DEPTH);

    logic [LUTRAM_AW-1:0] wr_ptr;
    logic [LUTRAM_AW-1:0] rd_ptr;
    logic [LUTRAM_LW-1:0] ram_cnt;
    logic [LUTRAM_LW-1:0] ram_cnt_nxt;
    logic                 out_vld;
    logic                 out_vld_nxt;
    logic                 wr_acc;
    logic                 load;
    logic [DATA_W-1:0]    ram_dout;

    lutram_sdp64 #(
        .DATA_W (DATA_W)
    ) u_ram (
        .WCLK (CLK),
        .WE   (wr_acc),
        .A    (wr_ptr),
        .D    (WR_DATA),
        .DPRA (rd_ptr),
        .DPO  (ram_dout)
    );

    // FULL is registered, so a pop at full never frees room this cycle.
    assign wr_acc = WR_EN & ~FULL;
    assign load   = (ram_cnt != '0) & (~out_vld | RD_READY);

    always_comb begin
        ram_cnt_nxt = ram_cnt;
        unique case ({wr_acc, load})
            2'b10:   ram_cnt_nxt = ram_cnt + 1'b1;
            2'b01:   ram_cnt_nxt = ram_cnt - 1'b1;
            default: ram_cnt_nxt = ram_cnt;
        endcase
    end

    always_comb begin
        out_vld_nxt = out_vld;
        if (load) begin
            out_vld_nxt = 1'b1;
        end else if (out_vld & RD_READY) begin
            out_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            out_vld <= 1'b0;
            RD_DATA <= '0;
            FULL    <= 1'b0;
            LEVEL   <= '0;
            ERR_OVF <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr  <= rd_ptr + 1'b1;
                RD_DATA <= ram_dout;
            end
            if (WR_EN & FULL) begin
                ERR_OVF <= 1'b1;
            end
            ram_cnt <= ram_cnt_nxt;
            out_vld <= out_vld_nxt;
            FULL    <= (ram_cnt_nxt == CNT_FULL);
            LEVEL   <= ram_cnt_nxt + LUTRAM_LW'(out_vld_nxt);
        end
    end

    assign RD_VALID = out_vld;

endmodule

// File: tb/tb_lutram_fifo64.sv
// Directed bench for lutram_fifo64 with an occupancy model and data scoreboard.
module tb_lutram_fifo64;

    logic       CLK = 1'b0;
    logic       RST;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       FULL;
    logic       RD_VALID;
    logic       RD_READY;
    logic [7:0] RD_DATA;
    logic [6:0] LEVEL;
    logic       ERR_OVF;

    lutram_fifo64 #(
        .DATA_W (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_EN    (WR_EN),
        .WR_DATA  (WR_DATA),
        .FULL     (FULL),
        .RD_VALID (RD_VALID),
        .RD_READY (RD_READY),
        .RD_DATA  (RD_DATA),
        .LEVEL    (LEVEL),
        .ERR_OVF  (ERR_OVF)
    );

    always #5 CLK = ~CLK;

    int         nvec = 0;
    int         nerr = 0;
    int         npop = 0;
    logic [7:0] sb[$];
    int         m_cnt = 0;
    bit         m_vld = 0;
    bit         m_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from current inputs, then check after it.
    task automatic step();
        bit acc;
        bit ld;
        acc = WR_EN && (m_cnt != 64);
        ld  = (m_cnt != 0) && (!m_vld || RD_READY);
        if (RST) begin
            sb.delete();
            m_cnt = 0;
            m_vld = 0;
            m_err = 0;
        end else begin
            if (m_vld && RD_READY) begin
                chk("hs_valid", 64'(RD_VALID), 64'd1);
                chk("hs_data", 64'(RD_DATA), 64'(sb[0]));
                void'(sb.pop_front());
                npop++;
            end
            if (WR_EN && m_cnt == 64) m_err = 1;
            if (acc) sb.push_back(WR_DATA);
            if (acc && !ld) m_cnt++;
            if (ld && !acc) m_cnt--;
            if (ld) m_vld = 1;
            else if (m_vld && RD_READY) m_vld = 0;
        end
        @(posedge CLK);
        #1;
        chk("level", 64'(LEVEL), 64'(m_cnt + int'(m_vld)));
        chk("full", 64'(FULL), 64'(m_cnt == 64));
        chk("valid", 64'(RD_VALID), 64'(m_vld));
        chk("err_ovf", 64'(ERR_OVF), 64'(m_err));
        if (m_vld) chk("head", 64'(RD_DATA), 64'(sb[0]));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
        WR_EN = 1'b0;
    endtask

    task automatic fill65();
        RD_READY = 1'b0;
        WR_EN = 1'b1;
        for (int i = 0; i < 65; i++) begin
            WR_DATA = 8'(i);
            step();
        end
        WR_EN = 1'b0;
    endtask

    task automatic drain(input int n);
        WR_EN = 1'b0;
        RD_READY = 1'b1;
        for (int i = 0; i < n; i++) step();
        RD_READY = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        WR_EN = 1'b0;
        WR_DATA = '0;
        RD_READY = 1'b0;
        step();
        step();
        RST = 1'b0;
        chk("rst_data", 64'(RD_DATA), 64'h0);
        chk("rst_level", 64'(LEVEL), 64'd0);

        // single write latency
        WR_EN = 1'b1;
        WR_DATA = 8'hA5;
        step();
        WR_EN = 1'b0;
        chk("lat_n_valid", 64'(RD_VALID), 64'd0);
        step();
        chk("lat_n1_valid", 64'(RD_VALID), 64'd1);
        chk("lat_n1_data", 64'(RD_DATA), 64'hA5);
        chk("lat_level", 64'(LEVEL), 64'd1);

        // fill to 65, overflow attempt, drain
        do_reset();
        fill65();
        chk("fill_full", 64'(FULL), 64'd1);
        chk("fill_level", 64'(LEVEL), 64'd65);
        chk("fill_head", 64'(RD_DATA), 64'h00);
        WR_EN = 1'b1;
        WR_DATA = 8'hFF;
        step();
        WR_EN = 1'b0;
        chk("ovf_err", 64'(ERR_OVF), 64'd1);
        chk("ovf_level", 64'(LEVEL), 64'd65);
        drain(66);
        chk("drain_empty", 64'(LEVEL), 64'd0);
        chk("drain_sb", 64'(sb.size()), 64'd0);

        // streaming at full rate across pointer wraps
        do_reset();
        npop = 0;
        WR_EN = 1'b1;
        RD_READY = 1'b1;
        for (int i = 0; i < 200; i++) begin
            WR_DATA = 8'(i);
            step();
        end
        chk("stream_pops", 64'(npop), 64'd198);
        drain(4);
        chk("stream_empty", 64'(LEVEL), 64'd0);

        // backpressure holds the head word
        do_reset();
        WR_EN = 1'b1;
        WR_DATA = 8'h3C;
        step();
        WR_DATA = 8'h3D;
        step();
        WR_EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_data", 64'(RD_DATA), 64'h3C);
            chk("bp_valid", 64'(RD_VALID), 64'd1);
        end
        drain(3);

        // simultaneous write and pop at full
        do_reset();
        fill65();
        WR_EN = 1'b1;
        RD_READY = 1'b1;
        WR_DATA = 8'hEE;
        step();
        WR_EN = 1'b0;
        RD_READY = 1'b0;
        chk("fp_err", 64'(ERR_OVF), 64'd1);
        chk("fp_full", 64'(FULL), 64'd0);
        chk("fp_level", 64'(LEVEL), 64'd64);
        drain(66);
        chk("fp_empty", 64'(LEVEL), 64'd0);

        // reset mid-operation discards stored words
        do_reset();
        WR_EN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            WR_DATA = 8'(8'h10 + i);
            step();
        end
        WR_EN = 1'b0;
        step();
        drain(3);
        RST = 1'b1;
        WR_EN = 1'b1;
        WR_DATA = 8'h99;
        step();
        RST = 1'b0;
        chk("mr_level", 64'(LEVEL), 64'd0);
        chk("mr_valid", 64'(RD_VALID), 64'd0);
        chk("mr_full", 64'(FULL), 64'd0);
        chk("mr_err", 64'(ERR_OVF), 64'd0);
        WR_DATA = 8'h77;
        step();
        WR_EN = 1'b0;
        chk("mr_lat0", 64'(RD_VALID), 64'd0);
        step();
        chk("mr_lat1", 64'(RD_VALID), 64'd1);
        chk("mr_first", 64'(RD_DATA), 64'h77);
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lutram_fifo64.md
# lutram_fifo64

Single-clock 64-entry FIFO built on distributed (LUT) RAM, DATA_W bits wide, with a registered first-word-fall-through output stage and a valid/ready read handshake. It is the reader side of the dual-port distributed RAM. The write port drives the RAM's synchronous write address. The FIFO read pointer drives the RAM's asynchronous read address, and a read controller drains the RAM into the output register. It serves as the standard small elastic buffer between streaming blocks in Verilator-simulated Xilinx designs.

## Interface
Parameters:
- DATA_W, default 8: data width in bits, legal range 1..64.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  reset, synchronous and active-high.
- WR_EN  in  1  write request.
- WR_DATA  in  DATA_W  write data, sampled when WR_EN=1 and FULL=0.
- FULL  out  1  RAM holds 64 entries; writes are ignored while FULL=1.
- RD_VALID  out  1  RD_DATA holds a valid word.
- RD_READY  in  1  consumer accepts RD_DATA when RD_VALID=1.
- RD_DATA  out  DATA_W  head-of-FIFO word, registered.
- LEVEL  out  7  total words held, counting RAM and output register; range 0..65.
- ERR_OVF  out  1  sticky flag, set by a write attempted while FULL=1.

## Operation
- State:
  - wr_ptr[5:0] and rd_ptr[5:0] wrap modulo 64.
  - ram_cnt[6:0] ranges 0..64.
  - out_vld is the output register's valid bit.
  - ERR_OVF is sticky.
- Write accept: wr_acc = WR_EN & ~FULL. On accept, mem[wr_ptr] ← WR_DATA and wr_ptr++.
- Output register load: load = (ram_cnt != 0) & (~out_vld | RD_READY). On load:
  - RD_DATA ← mem[rd_ptr], read asynchronously.
  - rd_ptr++.
  - out_vld ← 1.
- Output register drain: when out_vld & RD_READY & ~load, out_vld ← 0. RD_DATA keeps its stale value.
- ram_cnt update:
  - +1 on wr_acc only.
  - −1 on load only.
  - Unchanged when both or neither occur.
- FULL = (ram_cnt == 64), registered.
  - A write in the same cycle as a pop at full is still rejected; there is no write-through at full.
- LEVEL = ram_cnt + out_vld, registered, consistent with the post-edge state.
- ERR_OVF is set by WR_EN & FULL. It is cleared only by RST. The rejected data is dropped; no other state changes.
- RD_READY while RD_VALID=0 has no effect.
- RD_VALID must not fall without a handshake (out_vld & RD_READY).
- RD_DATA must not change while RD_VALID=1 & RD_READY=0.
- Ordering is strict FIFO. Maximum occupancy is 65 words: 64 in RAM plus 1 in the output register.

## Timing
- Reset values: FULL=0, RD_VALID=0, RD_DATA=0, LEVEL=0, ERR_OVF=0. Internally wr_ptr=rd_ptr=0 and ram_cnt=0.
  - RAM contents are not reset; they power up to 0.
  - Reset mid-operation discards all stored words. Stale RAM data must never be presented.
  - RST has priority over every write and read in the same cycle.
- Write-to-output latency when the FIFO is empty:
  - Write at edge N.
  - RD_VALID=1 with that data after edge N+1 (2-cycle latency).
  - There is no bypass path.
- Back-to-back throughput is 1 word per cycle in and out simultaneously, in steady state with RD_READY held high.
- FULL asserts after the edge that accepts the 64th word into RAM.
  - FULL deasserts after the first load that follows.
- Pointer wrap from 63 to 0 is seamless and adds no bubble.

## Structure
- Shared package/include lutram_pkg holds constants LUTRAM_DEPTH=64, LUTRAM_AW=6, LUTRAM_LW=7.
- Sub-module lutram_sdp64 holds the storage: a DATA_W-wide, 64-deep distributed RAM.
  - Synchronous write: WCLK, WE, A, D.
  - Asynchronous read on DPRA, output DPO.
  - Implemented as DATA_W bit-slices of the 64x1 dual-port primitive.
- The top level holds the pointers, counter, output register and flags.

## Test plan
1. Reset, then write 0xA5 at edge N with RD_READY=0:
   - RD_VALID=0 after edge N.
   - RD_VALID=1 and RD_DATA=0xA5 after edge N+1.
   - LEVEL=1.
2. Fill with 0x00..0x40 (65 writes, RD_READY=0):
   - 0x00 held in the output register and 0x01..0x40 in RAM; FULL=1; LEVEL=65.
   - A 66th write (0xFF) sets ERR_OVF=1; LEVEL stays 65.
   - Draining yields 0x00..0x40 in order; 0xFF never appears.
3. Continuous streaming with WR_EN=1 and RD_READY=1 for 200 cycles, data = counter:
   - After the 2-cycle fill, one word per cycle with no gaps.
   - Pointer wrap at 64 and 128 is invisible.
4. Backpressure: hold RD_READY=0 for 10 cycles while RD_VALID=1 with data 0x3C.
   - RD_DATA stays at 0x3C throughout.
   - RD_VALID stays high throughout.
5. At FULL=1, assert WR_EN=1 and RD_READY=1 together:
   - The write is rejected and ERR_OVF=1.
   - One word is popped and FULL=0 after the edge.
   - LEVEL=64.
6. Write 10 words, read 3, then pulse RST together with WR_EN:
   - After reset: LEVEL=0, RD_VALID=0, FULL=0, ERR_OVF=0.
   - The next write of 0x77 is the first word out, with 2-cycle latency.
